// File: rtl/t_gray_pkg.sv
// Shared helpers for the async FIFO pointer logic.
// Gray/binary conversion is done at a fixed maximum width and cast at the use site.
package t_gray_pkg;

    localparam int MAXW = 32;

    function automatic int pw_of(input int aw);
        return aw + 1;
    endfunction

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic logic [MAXW-1:0] gray_of(input logic [MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAXW-1:0] bin_of(input logic [MAXW-1:0] gray);
        logic [MAXW-1:0] b;
        b[MAXW-1] = gray[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gray[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/t_gray_sync2.sv
// Two-flop synchronizer for a Gray-coded bus crossing into clk.
module t_gray_sync2
    import t_gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/t_gray_wptr.sv
// Write-side pointer controller of an async FIFO: binary/Gray write pointer,
// synchronized read pointer, and full / almost-full / level / overflow status.
module t_gray_wptr
    import t_gray_pkg::*;
#(
    parameter int AW    = 4,
    parameter int AFULL = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic [AW:0]   rptr_gray_async,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wptr_gray,
    output logic          full,
    output logic          afull,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam int PW = pw_of(AW);
    localparam logic [PW-1:0] AF = PW'(AFULL);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rsync2;
    logic [PW-1:0] rbin;
    logic          ovf_q, ovf_d;

    t_gray_sync2 #(.W(PW)) u_rsync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rptr_gray_async),
        .q_o   (rsync2)
    );

    assign rbin = PW'(bin_of(MAXW'(rsync2)));

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full  = (wgray_q == {~rsync2[AW:AW-1], rsync2[AW-2:0]});
    assign level = wbin_q - rbin;
    assign afull = (level >= AF);
    assign wen   = inc & ~full;
    assign waddr = wbin_q[AW-1:0];

    assign wptr_gray = wgray_q;
    assign ovf       = ovf_q;

    always_comb begin
        wbin_d = wbin_q;
        ovf_d  = ovf_q;
        if (inc) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wbin_d = wbin_q + PW'(1);
            end
        end
        wgray_d = PW'(gray_of(MAXW'(wbin_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_t_gray_wptr.sv
// Directed bench for t_gray_wptr at AW=2, AFULL=3.
module tb_t_gray_wptr;

    logic       clk;
    logic       rst_n;
    logic       inc;
    logic [2:0] rptr_gray_async;
    logic       wen;
    logic [1:0] waddr;
    logic [2:0] wptr_gray;
    logic       full;
    logic       afull;
    logic [2:0] level;
    logic       ovf;

    int vectors    = 0;
    int miscompares = 0;

    t_gray_wptr #(.AW(2), .AFULL(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inc             (inc),
        .rptr_gray_async (rptr_gray_async),
        .wen             (wen),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .afull           (afull),
        .level           (level),
        .ovf             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/wptr"}, 32'(wptr_gray), 0);
        chk({tag, "/waddr"}, 32'(waddr), 0);
        chk({tag, "/level"}, 32'(level), 0);
        chk({tag, "/full"}, 32'(full), 0);
        chk({tag, "/afull"}, 32'(afull), 0);
        chk({tag, "/ovf"}, 32'(ovf), 0);
    endtask

    logic [2:0] fill_gray [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
    logic [1:0] fill_addr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] fill_lvl  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       fill_af   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       fill_full [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic [2:0] wrap_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                                  3'b111, 3'b101, 3'b100, 3'b000};
    logic [2:0] wrap_lvl  [8] = '{3'd1, 3'd2, 3'd3, 3'd3,
                                  3'd3, 3'd3, 3'd3, 3'd3};

    logic [2:0] prev;

    initial begin
        rst_n = 1'b0;
        inc = 1'b0;
        rptr_gray_async = 3'b000;

        // Reset before the first clock edge
        #1;
        chk_zero("reset");
        chk("reset/wen", 32'(wen), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Fill
        @(negedge clk);
        inc = 1'b1;
        #1;
        chk("fill/wen0", 32'(wen), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("fill%0d/wptr", i), 32'(wptr_gray), 32'(fill_gray[i]));
            chk($sformatf("fill%0d/waddr", i), 32'(waddr), 32'(fill_addr[i]));
            chk($sformatf("fill%0d/level", i), 32'(level), 32'(fill_lvl[i]));
            chk($sformatf("fill%0d/afull", i), 32'(afull), 32'(fill_af[i]));
            chk($sformatf("fill%0d/full", i), 32'(full), 32'(fill_full[i]));
        end

        // Overflow: inc still high while full
        chk("ovf/wen", 32'(wen), 0);
        chk("ovf/pre", 32'(ovf), 0);
        @(negedge clk);
        inc = 1'b0;
        chk("ovf/wptr", 32'(wptr_gray), 32'b110);
        chk("ovf/set", 32'(ovf), 1);
        @(negedge clk);
        chk("ovf/sticky", 32'(ovf), 1);
        chk("ovf/level", 32'(level), 4);

        // Read release
        rptr_gray_async = 3'b001;
        @(negedge clk);
        chk("rel/full1", 32'(full), 1);
        @(negedge clk);
        chk("rel/full2", 32'(full), 0);
        chk("rel/level", 32'(level), 3);
        chk("rel/afull", 32'(afull), 1);
        chk("rel/ovf", 32'(ovf), 1);

        // Reset, then wrap with a lagging reader
        rst_n = 1'b0;
        rptr_gray_async = 3'b000;
        #1;
        chk_zero("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        prev = 3'b000;
        for (int j = 1; j <= 8; j++) begin
            inc = 1'b1;
            @(negedge clk);
            inc = 1'b0;
            chk($sformatf("wrap%0d/wptr", j), 32'(wptr_gray), 32'(wrap_gray[j-1]));
            chk($sformatf("wrap%0d/1bit", j), $countones(prev ^ wptr_gray), 1);
            chk($sformatf("wrap%0d/level", j), 32'(level), 32'(wrap_lvl[j-1]));
            chk($sformatf("wrap%0d/full", j), 32'(full), 0);
            prev = wptr_gray;
            if (j >= 2) begin
                rptr_gray_async = wrap_gray[j-1] ^ 3'b000;
                rptr_gray_async = (j == 2) ? 3'b000 : wrap_gray[j-3];
            end
            @(negedge clk);
            chk($sformatf("wrap%0d/idlefull", j), 32'(full), 0);
        end

        // Reset mid-stream at level 2
        rst_n = 1'b0;
        rptr_gray_async = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        inc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inc = 1'b0;
        chk("mid/level", 32'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid");
        @(negedge clk);
        rst_n = 1'b1;
        inc = 1'b1;
        #1;
        chk("mid/waddr0", 32'(waddr), 0);
        chk("mid/wen", 32'(wen), 1);
        @(negedge clk);
        inc = 1'b0;
        chk("mid/waddr1", 32'(waddr), 1);
        chk("mid/wptr1", 32'(wptr_gray), 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
